// File: rtl/vwb_pkg.sv
// vwb_pkg: shared sizing, entry record and FSM states for the victim writeback buffer
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
package vwb_pkg;
  localparam int VWB_INDEX_WIDTH = 5;
  localparam int VWB_SET_SIZE    = 2;
  localparam int VWB_TAG_WIDTH   = 23;
  localparam int VWB_LINE_WORDS  = 4;
  localparam int VWB_ENTRIES     = 4;
  localparam int WORD_BITS       = $clog2(VWB_LINE_WORDS);
  localparam int PTR_BITS        = $clog2(VWB_ENTRIES);
  typedef struct packed {
    logic [VWB_TAG_WIDTH-1:0]    tag;
    logic [VWB_INDEX_WIDTH-1:0]  index;
    logic [VWB_SET_SIZE-1:0]     way;
    logic [32*VWB_LINE_WORDS-1:0] data;
  } vwb_entry_t;
  typedef enum logic {IDLE, SEND} vwb_state_e;
endpackage

// File: rtl/vwb_match.sv
// vwb_match: parallel {index,tag} probe over live FIFO entries, youngest match wins
module vwb_match
  import vwb_pkg::*;
(
  input  vwb_entry_t                    entries [VWB_ENTRIES],
  input  logic [PTR_BITS-1:0]           head,
  input  logic [PTR_BITS:0]             count,
  input  logic [VWB_INDEX_WIDTH-1:0]    index,
  input  logic [VWB_TAG_WIDTH-1:0]      tag,
  output logic                          hit,
  output logic [32*VWB_LINE_WORDS-1:0]  data
);
  logic unused_way;
  assign unused_way = ^entries[head].way;
  // walk oldest to youngest so later matches overwrite earlier ones
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < VWB_ENTRIES; k++) begin
      if ((PTR_BITS+1)'(k) < count &&
          entries[head + PTR_BITS'(k)].index == index &&
          entries[head + PTR_BITS'(k)].tag == tag) begin
        hit  = 1'b1;
        data = entries[head + PTR_BITS'(k)].data;
      end
    end
  end
endmodule

// File: rtl/victim_writeback_buffer.sv
// victim_writeback_buffer: FIFO of dirty victims drained as word-serial write bursts.
// Define VWB_FORWARD_EN to build the miss-path lookup; otherwise lookup outputs are tied 0.
module victim_writeback_buffer
  import vwb_pkg::*;
#(
  parameter int INDEX_WIDTH = VWB_INDEX_WIDTH,
  parameter int SET_SIZE    = VWB_SET_SIZE,
  parameter int TAG_WIDTH   = VWB_TAG_WIDTH,
  parameter int LINE_WORDS  = VWB_LINE_WORDS,
  parameter int ENTRIES     = VWB_ENTRIES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      evict_valid,
  output logic                      evict_ready,
  input  logic                      evict_dirty,
  input  logic [INDEX_WIDTH-1:0]    evict_index,
  input  logic [SET_SIZE-1:0]       evict_way,
  input  logic [TAG_WIDTH-1:0]      evict_tag,
  input  logic [32*LINE_WORDS-1:0]  evict_data,
  output logic                      mem_wvalid,
  input  logic                      mem_wready,
  output logic [`ADDR_WIDTH-1:0]    mem_waddr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_wlast,
  input  logic [INDEX_WIDTH-1:0]    lookup_index,
  input  logic [TAG_WIDTH-1:0]      lookup_tag,
  output logic                      lookup_hit,
  output logic [32*LINE_WORDS-1:0]  lookup_data,
  output logic                      empty
);
  localparam int CW = PTR_BITS + 1;
  vwb_state_e state_q, state_d;
  logic [WORD_BITS-1:0] beat_q, beat_d;
  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_BITS:0] count_q, count_d;
  vwb_entry_t entries_q [VWB_ENTRIES];
  vwb_entry_t head_e, entry_d;
  logic push, pop, send, unused_ok;
  assign head_e      = entries_q[head_q];
  assign entry_d     = '{tag: evict_tag, index: evict_index, way: evict_way, data: evict_data};
  assign send        = state_q == SEND;
  // full check uses the registered count, so a same-cycle pop never frees a slot
  assign evict_ready = count_q != CW'(VWB_ENTRIES);
  assign push        = evict_valid && evict_ready && evict_dirty;
  assign pop         = send && mem_wready && mem_wlast;
  assign mem_wvalid  = send;
  assign mem_wlast   = send && beat_q == WORD_BITS'(VWB_LINE_WORDS-1);
  assign mem_waddr   = send ? {head_e.tag, head_e.index, beat_q, 2'b00} : '0;
  assign mem_wdata   = send ? head_e.data[{beat_q, 5'd0} +: 32] : '0;
  assign empty       = count_q == '0 && state_q == IDLE;
  always_comb begin
    head_d  = head_q + PTR_BITS'(pop);
    tail_d  = tail_q + PTR_BITS'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = send ? (pop ? IDLE : SEND) : (count_q != '0 ? SEND : IDLE);
    beat_d  = send ? (pop ? '0 : beat_q + WORD_BITS'(mem_wready)) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= entry_d;
  end
`ifdef VWB_FORWARD_EN
  vwb_match u_match (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .index   (lookup_index),
    .tag     (lookup_tag),
    .hit     (lookup_hit),
    .data    (lookup_data)
  );
  assign unused_ok = ^head_e.way;
`else
  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;
  assign unused_ok   = ^{head_e.way, lookup_index, lookup_tag};
`endif
endmodule
